// File: rtl/status_register_unit_if.sv
// Bundle of the EXE/ID-side signals of the NZCV status register unit.
// The master drives pipeline control and operands; the slave returns SR, the stall request and the pending count.
interface status_register_unit_if #(
    parameter int WIDTH = 32
);
    logic             freeze;
    logic             flush;
    logic             exe_s;
    logic [3:0]       exe_cmd;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             id_s;
    logic [3:0]       id_cond;
    logic             id_valid;
    logic [3:0]       sr;
    logic             sr_hazard;
    logic [1:0]       pending;

    modport master (
        output freeze, flush, exe_s, exe_cmd, op_a, op_b, id_s, id_cond, id_valid,
        input  sr, sr_hazard, pending
    );

    modport slave (
        input  freeze, flush, exe_s, exe_cmd, op_a, op_b, id_s, id_cond, id_valid,
        output sr, sr_hazard, pending
    );
endinterface

// File: rtl/status_register_unit.sv
// NZCV flag generation from the EXE-stage operation, the architectural status register,
// and tracking of in-flight flag writers so that conditional instructions in ID stall on a stale SR.
module status_register_unit #(
    parameter int WIDTH       = 32,
    parameter int MAX_PENDING = 3
) (
    input logic                  clk,
    input logic                  rst,
    status_register_unit_if.slave bus
);

    typedef enum logic [3:0] {
        CMD_MOV = 4'b0001,
        CMD_MVN = 4'b1001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000
    } alu_cmd_e;

    localparam logic [1:0] PEND_MAX = 2'(MAX_PENDING);
    localparam logic [3:0] COND_AL  = 4'b1110;

    logic [3:0]       sr_q;
    logic [1:0]       pending_q;
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] res;
    logic             c_new;
    logic             v_new;
    logic             c_in;
    logic             a_msb;
    logic             b_msb;
    logic             inc;
    logic             dec;

    // ADC/SBC take the carry from the architectural register, never from the flags being produced now.
    assign c_in  = sr_q[1];
    assign a_msb = bus.op_a[WIDTH-1];
    assign b_msb = bus.op_b[WIDTH-1];

    // NOTE: every output of this block is assigned a default first, so no path can infer a latch.
    always_comb begin
        ext   = '0;
        res   = bus.op_b;
        c_new = sr_q[1];
        v_new = sr_q[0];
        unique case (bus.exe_cmd)
            CMD_MOV: res = bus.op_b;
            CMD_MVN: res = ~bus.op_b;
            CMD_ADD, CMD_ADC: begin
                ext   = {1'b0, bus.op_a} + {1'b0, bus.op_b}
                      + {{WIDTH{1'b0}}, (bus.exe_cmd == CMD_ADC) & c_in};
                res   = ext[WIDTH-1:0];
                c_new = ext[WIDTH];
                v_new = (a_msb == b_msb) && (res[WIDTH-1] != a_msb);
            end
            CMD_SUB, CMD_SBC: begin
                // a - b - ~C as a + ~b + C, so the carry out is the inverted borrow.
                ext   = {1'b0, bus.op_a} + {1'b0, ~bus.op_b}
                      + {{WIDTH{1'b0}}, (bus.exe_cmd == CMD_SUB) | c_in};
                res   = ext[WIDTH-1:0];
                c_new = ext[WIDTH];
                v_new = (a_msb != b_msb) && (res[WIDTH-1] != a_msb);
            end
            CMD_AND: res = bus.op_a & bus.op_b;
            CMD_ORR: res = bus.op_a | bus.op_b;
            CMD_EOR: res = bus.op_a ^ bus.op_b;
            default: res = bus.op_b;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= 4'b0000;
        end else if (bus.exe_s && !bus.freeze) begin
            sr_q <= {res[WIDTH-1], (res == '0), c_new, v_new};
        end
    end

    assign inc = bus.id_s && bus.id_valid && !bus.flush;
    assign dec = bus.exe_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 2'd0;
        end else if (!bus.freeze) begin
            unique case ({inc, dec})
                2'b10:   if (pending_q != PEND_MAX) pending_q <= pending_q + 2'd1;
                2'b01:   if (pending_q != 2'd0)     pending_q <= pending_q - 2'd1;
                default: pending_q <= pending_q;
            endcase
        end
    end

    assign bus.sr        = sr_q;
    assign bus.pending   = pending_q;
    assign bus.sr_hazard = bus.id_valid && (bus.id_cond != COND_AL)
                        && ((pending_q != 2'd0) || bus.exe_s);

endmodule

// File: doc/status_register_unit.md
Name: status_register_unit

Overview:
- Producer side of the NZCV status word consumed by the ID-stage condition check.
- Computes N/Z/C/V from the EXE-stage operation and holds them in the architectural status register SR.
- Tracks flag-setting instructions in flight between ID and EXE and raises a stall when a conditional instruction in ID would read a stale SR.
- Sits beside the EXE stage. SR output feeds the ID stage.

Parameters:
- WIDTH, 32, datapath width of operands.
- MAX_PENDING, 3, maximum tracked in-flight flag writers (counter saturates here).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- freeze  input  1  pipeline stall. Holds SR and pending count.
- flush  input  1  branch flush. Squashes the in-flight ID→EXE flag writer.
- exe_s  input  1  EXE instruction has S bit set and is valid
- exe_cmd  input  4  EXE ALU command
- op_a  input  WIDTH  EXE first operand (Rn value)
- op_b  input  WIDTH  EXE second operand (shifter output)
- id_s  input  1  ID instruction sets flags and is valid
- id_cond  input  4  ID condition field
- id_valid  input  1  ID holds a real instruction
- sr  output  4  {N,Z,C,V}: bit3=N, bit2=Z, bit1=C, bit0=V
- sr_hazard  output  1  stall request to ID
- pending  output  2  in-flight flag-writer count, for debug

Behaviour:
- Reset, synchronous: sr=4'b0000, pending=0, sr_hazard=0.
- Command encoding:
  - MOV 0001, MVN 1001
  - ADD 0010, ADC 0011, SUB 0100, SBC 0101
  - AND 0110, ORR 0111, EOR 1000
  - Any other code is treated as a logic op on result=op_b.
- Internal result r (WIDTH bits) per command:
  - MOV=op_b, MVN=~op_b
  - ADD=a+b, ADC=a+b+C
  - SUB=a-b, SBC=a-b-~C
  - AND/ORR/EOR bitwise
- Carry is computed at WIDTH+1 bits.
- Flag rules:
  - N=r[WIDTH-1]
  - Z=(r==0)
  - ADD/ADC: C=carry out. V=(a[MSB]==b[MSB]) && (r[MSB]!=a[MSB]).
  - SUB/SBC: C=NOT borrow, so a>=b gives C=1. V=(a[MSB]!=b[MSB]) && (r[MSB]!=a[MSB]).
  - Logic and move ops: C and V keep their old values.
- SR update:
  - At the clock edge, sr loads the new flags iff exe_s=1 and freeze=0.
  - Otherwise sr holds.
  - ADC/SBC use the registered C, not the C being produced in the same cycle.
- Pending counter, when freeze=0 (all cases evaluated simultaneously):
  - Increment if id_s && id_valid && !flush.
  - Decrement if exe_s.
  - Increment and decrement in the same cycle: count is unchanged.
  - Saturates at MAX_PENDING and at 0. A decrement at 0 is ignored.
  - flush=1: the ID-side increment is dropped. The EXE-side decrement still applies.
- freeze=1: counter and sr hold; flush is ignored.
- sr_hazard is combinational: id_valid && (id_cond!=4'b1110) && (pending!=0 || exe_s).
  - Cond 1110 (AL) never stalls.
  - id_cond 1111 is treated as conditional.
- Reset mid-operation clears sr and pending on the next edge regardless of freeze or flush.
- Latency: flags are visible on sr one cycle after the EXE cycle with exe_s=1.

Test Plan:
- Reset: rst=1 for 2 cycles → sr=0000, pending=0, sr_hazard=0.
- ADD with S, a=32'h7FFFFFFF, b=1 → next cycle sr=1001 (N=1, Z=0, C=0, V=1).
- SUB with S, a=5, b=5 → sr=0110 (Z=1, C=1). Then AND with S, a=0xF0, b=0x0F → sr=0110 (C and V retained).
- ADC with prior C=1, a=32'hFFFFFFFF, b=0 → r=0, sr=0110. Setting exe_s=0 with the same operands leaves sr unchanged.
- id_s=1 in ID, then the next cycle id_cond=0000 (EQ) → sr_hazard=1 until the writer completes EXE. id_cond=1110 → sr_hazard=0 throughout.
- Flush plus simultaneous events:
  - flush=1 while id_s=1 → pending does not increment.
  - Same cycle, freeze=1 with exe_s=1 → sr and pending both hold.
  - rst asserted mid-stream with pending=2 → pending=0 and sr=0000 next edge.
